muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative, parametrised RV32M multiply/divide unit: the sequential companion to the single-cycle ALU in the execute stage. Covers all eight M-extension operations through one shared shift-add / restoring-divide datapath, one bit per cycle. Valid/ready handshakes on input and output let the pipeline stall cleanly. It also supports a synchronous flush for branch/trap squash.

## Interface
- XLEN, 32, operand/result width; must be ≥ 4.
- CNT_W, $clog2(XLEN+1), iteration counter width; derived, not overridden.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; highest priority after reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; equals (state==IDLE && !flush)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand (multiplicand/dividend)
- b  in  XLEN  rs2 operand (multiplier/divisor)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result; held stable while out_valid && !out_ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: accept on in_valid && in_ready. Latch op, operand magnitudes and result sign flags.
  - Normal operations go to CALC with count = XLEN.
  - Special divide cases go straight to DONE with result loaded.
- Signedness:
  - a signed for MULH, MULHSU, DIV, REM.
  - b signed for MULH, DIV, REM.
  - Operands are converted to magnitudes; the final result is negated when needed.
- Product sign = sign(a) XOR sign(b). Quotient sign is the same. Remainder sign = sign(a).
- CALC, multiply: one conditional add of the multiplicand and a right shift per cycle over a 2·XLEN product register.
- CALC, divide: restoring divide; shift the remainder left, trial-subtract, set the quotient bit.
- CALC: count decrements each cycle; at count==1 go to FIX.
- FIX: apply sign correction over the full 2·XLEN (multiply) or XLEN (divide) width, then select:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Then go to DONE.
- DONE: out_valid=1. On out_ready go to IDLE. There is no new accept in the same cycle, because in_ready is low in DONE.
- Special cases, RISC-V mandated, no trap:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most-negative, b = −1, DIV/REM only): DIV gives a; REM gives 0.
- flush=1: next state IDLE from any state. out_valid drops on the next edge and no result is delivered. A request presented in the same cycle is not accepted.
- Arithmetic is modulo 2^XLEN for MUL. Multiply results are exact over 2·XLEN bits.

## Timing
- Reset (async assert, sync-to-clk deassert assumed at system level): state IDLE, out_valid 0, result 0, busy 0, in_ready 1 (unless flush), counter 0.
- Accept at edge E0. CALC occupies edges E1..E_XLEN and FIX is E_XLEN+1. out_valid is high from after E_XLEN+1: latency XLEN+1 cycles (33 for XLEN=32).
- Special divide cases: out_valid high from after E0, latency 1 cycle.
- Result-consumed edge: back in IDLE, and in_ready high the following cycle. Throughput is at best one operation per XLEN+3 cycles.
- result changes only on the transition into DONE. It keeps its last value in IDLE and is not cleared.
- rst_n low mid-operation: immediate return to reset values; no partial result is visible.
- flush and out_ready both high in DONE: go to IDLE; the result is treated as dropped.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB; out_valid first high exactly 33 cycles after the accept edge; busy high throughout.
- a=b=0x80000000:
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
- a=b=0xFFFFFFFF:
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE.
  - MUL → 0x00000001.
- a=0xFFFFFFF9 (−7), b=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=2 → 0x7FFFFFFF.
- Special cases, each with out_valid one cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold out_ready low for 10 cycles after out_valid rises.
  - result must stay constant; in_ready low; in_valid ignored.
  - Raise out_ready: IDLE next cycle, and a new request is accepted the cycle after.
- Flush and reset during an operation:
  - Assert flush for 1 cycle at CALC cycle 10 → IDLE next edge; out_valid never rises; the next request completes correctly.
  - Pull rst_n low asynchronously mid-CALC → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide
// datapath retiring one bit per cycle, with valid/ready handshakes and flush.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   state_e              state_q, state_d;
   op_e                 op_in;
   op_e                 op_q;
   logic                is_div_q;
   logic                neg_q_q;
   logic                neg_r_q;
   logic [2*XLEN-1:0]   prod_q;
   logic [XLEN-1:0]     opnd_q;
   logic [CNT_W-1:0]    count_q;
   logic [XLEN-1:0]     result_q;

   logic                accept;
   logic                step;
   logic                fix_go;

   // Operand decode and special-case detection at the accept point.
   logic                is_div_in;
   logic                is_rem_in;
   logic                a_signed;
   logic                b_signed;
   logic                a_neg;
   logic                b_neg;
   logic [XLEN-1:0]     a_mag;
   logic [XLEN-1:0]     b_mag;
   logic                div_by_zero;
   logic                sgn_ovf;
   logic                special_in;
   logic [XLEN-1:0]     special_res;

   assign op_in     = op_e'(op);
   assign is_div_in = op[2];
   assign is_rem_in = op[2] & op[1];
   assign a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
   assign b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
   assign a_neg     = a_signed & a[XLEN-1];
   assign b_neg     = b_signed & b[XLEN-1];
   // The magnitude of the most-negative value is 2^(XLEN-1), which still fits unsigned.
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;

   assign div_by_zero = is_div_in && (b == '0);
   assign sgn_ovf     = is_div_in && b_signed &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign special_in  = div_by_zero || sgn_ovf;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      special_res = '0;
      if (div_by_zero) begin
         special_res = is_rem_in ? a : '1;
      end else if (sgn_ovf) begin
         special_res = is_rem_in ? '0 : a;
      end
   end

   // One iteration of each algorithm over the shared product/remainder register.
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_shift;
   logic [XLEN:0]       div_diff;
   logic                div_fits;
   logic [2*XLEN-1:0]   div_next;

   always_comb begin
      mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, prod_q[XLEN-1:1]};

      // High half is the partial remainder, low half shifts the dividend out
      // while the quotient bits shift in.
      div_shift = prod_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      div_fits  = ~div_diff[XLEN];
      div_next  = {(div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                   prod_q[XLEN-2:0], div_fits};
   end

   // Sign correction and result selection, applied in FIX.
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix;
   logic [XLEN-1:0]     rem_fix;
   logic [XLEN-1:0]     fix_res;

   always_comb begin
      prod_fix = neg_q_q ? -prod_q : prod_q;
      quo_fix  = neg_q_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
      rem_fix  = neg_r_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = quo_fix;
         default:                      fix_res = rem_fix;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush overrides every transition, including an accept in the same cycle.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      step      = 1'b0;
      fix_go    = 1'b0;
      in_ready  = (state_q == S_IDLE) && !flush;
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  accept  = 1'b1;
                  state_d = special_in ? S_DONE : S_CALC;
               end
            end
            S_CALC: begin
               step = 1'b1;
               if (count_q == CNT_W'(1)) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               fix_go  = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_MUL;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         prod_q   <= '0;
         opnd_q   <= '0;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q     <= op_in;
            is_div_q <= is_div_in;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            count_q  <= CNT_W'(XLEN);
            // Multiply: multiplier in the low half, multiplicand held aside.
            // Divide: dividend in the low half, divisor held aside.
            prod_q   <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
            opnd_q   <= is_div_in ? b_mag : a_mag;
            if (special_in) begin
               result_q <= special_res;
            end
         end else if (step) begin
            prod_q  <= is_div_q ? div_next : mul_next;
            count_q <= count_q - 1'b1;
         end else if (fix_go) begin
            result_q <= fix_res;
         end
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops them on each output handshake.
module tb_muldiv_unit;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   localparam int LAT_NORMAL  = 33;  // edges from accept until out_valid is visible
   localparam int LAT_SPECIAL = 0;   // visible right after the accept edge

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
      end
   endtask

   // Monitor: compares each delivered result against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got 0x%08h, expected no output", result);
         end else begin
            check(name_q.pop_front(), result, exp_q.pop_front());
         end
      end
   end

   task automatic expect_result(input logic [31:0] want, input string name);
      exp_q.push_back(want);
      name_q.push_back(name);
   endtask

   // Present a request and return #1 after its accept edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op       = o;
      a        = aa;
      b        = bb;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat, input string name);
      int lat     = 0;
      bit busy_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_busy"}, {31'b0, busy_ok & busy}, 32'd1);
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] want, input int exp_lat, input string name);
      expect_result(want, name);
      issue(o, aa, bb);
      wait_valid(exp_lat, name);
      @(posedge clk); #1;
   endtask

   initial begin
      bit ok;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 3'b000;
      a         = '0;
      b         = '0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check("reset_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Multiply forms
      run(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_NORMAL, "mul_7_m3");
      run(MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_NORMAL, "mulh_min_min");
      run(MULHU,  32'h80000000, 32'h80000000, 32'h40000000, LAT_NORMAL, "mulhu_8000");
      run(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_NORMAL, "mulhsu_ones");
      run(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORMAL, "mulhu_ones");
      run(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_NORMAL, "mul_ones");

      // Divide forms
      run(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_NORMAL, "div_m7_2");
      run(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_NORMAL, "rem_m7_2");
      run(DIVU,   32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, LAT_NORMAL, "divu_ones_2");
      run(DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_NORMAL, "divu_no_ovf");

      // Special cases complete without iterating
      run(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPECIAL, "div_by_zero");
      run(REMU,   32'd5,        32'd0,        32'd5,        LAT_SPECIAL, "remu_by_zero");
      run(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPECIAL, "div_overflow");
      run(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPECIAL, "rem_overflow");

      // Backpressure: result held, new requests refused while DONE waits
      out_ready = 1'b0;
      expect_result(32'd14, "bp_divu_100_7");
      issue(DIVU, 32'd100, 32'd7);
      wait_valid(LAT_NORMAL, "bp_divu");
      in_valid = 1'b1;
      op       = MUL;
      a        = 32'd3;
      b        = 32'd3;
      ok       = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (result !== 32'd14 || in_ready || !out_valid) ok = 1'b0;
         @(posedge clk); #1;
      end
      check("bp_hold_stable", {31'b0, ok}, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_busy", {31'b0, busy}, 32'd0);
      check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
      expect_result(32'd2, "bp_remu_100_7");
      issue(REMU, 32'd100, 32'd7);
      check("bp_next_accepted", {31'b0, busy}, 32'd1);
      wait_valid(LAT_NORMAL, "bp_remu");
      @(posedge clk); #1;

      // Flush at CALC cycle 10: nothing is delivered
      issue(MUL, 32'd1234, 32'd5678);
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      check("flush_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_to_idle", {31'b0, busy}, 32'd0);
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) ok = 1'b0;
         @(posedge clk); #1;
      end
      check("flush_no_output", {31'b0, ok}, 32'd1);
      run(MUL, 32'd3, 32'd5, 32'd15, LAT_NORMAL, "after_flush_mul");

      // Flush together with a request in IDLE: request refused
      flush    = 1'b1;
      in_valid = 1'b1;
      op       = DIV;
      a        = 32'd9;
      b        = 32'd0;
      #1;
      check("flush_idle_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_idle_not_accepted", {31'b0, busy}, 32'd0);

      // Asynchronous reset mid-CALC
      issue(MULHU, 32'h12345678, 32'h9ABCDEF0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", {31'b0, busy}, 32'd0);
      check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("async_rst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(MULHU, 32'h12345678, 32'h00000010, 32'h00000001, LAT_NORMAL, "after_rst_mulhu");

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
